// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped 64-bit machine timer:
// register indices, CTRL bit positions, reset values and the byte-lane merge helper.
package timer_pkg;

    typedef enum logic [2:0] {
        REG_TIME_LO  = 3'd0,
        REG_TIME_HI  = 3'd1,
        REG_CMP_LO   = 3'd2,
        REG_CMP_HI   = 3'd3,
        REG_CTRL     = 3'd4,
        REG_PRESCALE = 3'd5,
        REG_RSVD_6   = 3'd6,
        REG_RSVD_7   = 3'd7
    } reg_idx_e;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam logic [63:0] CMP_RESET = '1;

    // Each set bit of sel replaces one byte of old_val with the matching byte of wr_val.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] wr_val,
        input logic [3:0]  sel
    );
        logic [31:0] result;
        result = old_val;
        for (int lane = 0; lane < 4; lane++) begin
            if (sel[lane]) begin
                result[8*lane +: 8] = wr_val[8*lane +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// 16-bit reloadable down-counter; emits a one-cycle tick when it reaches zero while running.
module prescaler (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        load,
    input  logic [15:0] value,
    output logic        tick
);

    logic [15:0] pre;

    assign tick = run && (pre == 16'd0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            pre <= 16'd0;
        end else if (load || tick) begin
            pre <= value;
        end else if (run) begin
            pre <= pre - 16'd1;
        end
    end

endmodule

// File: rtl/timer.sv
// Memory-mapped 64-bit machine timer bus slave with prescaler, compare register,
// atomic LO/HI read via a high-word shadow, and a registered level interrupt.
module timer
    import timer_pkg::*;
#(
    parameter int ADDR_BITS = 26,
    parameter int WORD_BITS = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_BITS-1:0] in,
    output logic [WORD_BITS-1:0] out,
    input  logic                 write,
    input  logic [3:0]           select,
    input  logic                 strobe,
    output logic                 ack,
    output logic                 retry,
    output logic                 irq
);

    reg_idx_e    idx;
    logic        rd_en;
    logic        wr_en;
    logic        wr_time_lo;
    logic        wr_time_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_ctrl;
    logic        wr_prescale;

    logic [63:0] mtime;
    logic [63:0] cmp;
    logic [31:0] hi_shadow;
    logic [1:0]  ctrl;
    logic [15:0] prescale;

    logic [31:0] rdata;
    logic [31:0] time_lo_wdata;
    logic [31:0] time_hi_wdata;
    logic [31:0] cmp_lo_wdata;
    logic [31:0] cmp_hi_wdata;
    logic [31:0] ctrl_wdata;
    logic [31:0] prescale_wdata;
    logic [15:0] prescale_next;
    logic        tick;
    logic        unused_bits;

    assign idx   = reg_idx_e'(addr[4:2]);
    assign rd_en = strobe && !write;
    assign wr_en = strobe && write;
    assign retry = 1'b0;

    assign unused_bits = ^{addr[ADDR_BITS-1:5], addr[1:0],
                           ctrl_wdata[31:2], prescale_wdata[31:16]};

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        wr_time_lo  = 1'b0;
        wr_time_hi  = 1'b0;
        wr_cmp_lo   = 1'b0;
        wr_cmp_hi   = 1'b0;
        wr_ctrl     = 1'b0;
        wr_prescale = 1'b0;
        rdata       = 32'd0;
        unique case (idx)
            REG_TIME_LO:  begin wr_time_lo  = wr_en; rdata = mtime[31:0];          end
            REG_TIME_HI:  begin wr_time_hi  = wr_en; rdata = hi_shadow;            end
            REG_CMP_LO:   begin wr_cmp_lo   = wr_en; rdata = cmp[31:0];            end
            REG_CMP_HI:   begin wr_cmp_hi   = wr_en; rdata = cmp[63:32];           end
            REG_CTRL:     begin wr_ctrl     = wr_en; rdata = {30'd0, ctrl};        end
            REG_PRESCALE: begin wr_prescale = wr_en; rdata = {16'd0, prescale};    end
            default:      rdata = 32'd0;
        endcase
    end

    always_comb begin
        time_lo_wdata  = merge_bytes(mtime[31:0], in[31:0], select);
        time_hi_wdata  = merge_bytes(mtime[63:32], in[31:0], select);
        cmp_lo_wdata   = merge_bytes(cmp[31:0], in[31:0], select);
        cmp_hi_wdata   = merge_bytes(cmp[63:32], in[31:0], select);
        ctrl_wdata     = merge_bytes({30'd0, ctrl}, in[31:0], select);
        prescale_wdata = merge_bytes({16'd0, prescale}, in[31:0], select);
        prescale_next  = wr_prescale ? prescale_wdata[15:0] : prescale;
    end

    // The reload value tracks a same-cycle PRESCALE write so load and reload share one input.
    prescaler u_prescaler (
        .clock (clock),
        .reset (reset),
        .run   (ctrl[CTRL_RUN]),
        .load  (wr_prescale),
        .value (prescale_next),
        .tick  (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            ack       <= 1'b0;
            out       <= '0;
            irq       <= 1'b0;
            mtime     <= 64'd0;
            cmp       <= CMP_RESET;
            hi_shadow <= 32'd0;
            ctrl      <= 2'd0;
            prescale  <= 16'd0;
        end else begin
            ack <= strobe;
            out <= rd_en ? rdata : '0;

            if (rd_en && idx == REG_TIME_LO) begin
                hi_shadow <= mtime[63:32];
            end

            // A software write to either TIME half suppresses that cycle's increment.
            if (wr_time_lo) begin
                mtime[31:0] <= time_lo_wdata;
            end else if (wr_time_hi) begin
                mtime[63:32] <= time_hi_wdata;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr_cmp_lo) cmp[31:0]  <= cmp_lo_wdata;
            if (wr_cmp_hi) cmp[63:32] <= cmp_hi_wdata;
            if (wr_ctrl)   ctrl       <= ctrl_wdata[1:0];
            prescale <= prescale_next;

            irq <= ctrl[CTRL_IRQ_EN] && (mtime >= cmp);
        end
    end

endmodule

// File: doc/timer.md
# timer

Memory-mapped 64-bit machine timer occupying the free `'b01 == addr[27:26]` window of the SoC data bus, beside RAM, UART and video. It answers the CPU data port with the same strobe/ack/retry handshake as the other bus slaves. It keeps a prescaled 64-bit time counter and a 64-bit compare register, and drives a level interrupt `irq` toward the CPU.

## Interface
- `ADDR_BITS`, 26: width of the byte address seen by the slave (SoC passes `addr[25:0]`).
- `WORD_BITS`, 32: bus data width. Only 32 is supported.
- `clock` in 1: bus clock (77.5 MHz); the only clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `addr` in ADDR_BITS: byte address; register index is `addr[4:2]`, other bits ignored.
- `in` in 32: write data.
- `out` out 32: read data; valid only while `ack` is high, 0 otherwise.
- `write` in 1: 1 = write, 0 = read.
- `select` in 4: byte enables, bit n covers `in[8n+7:8n]`.
- `strobe` in 1: request, already qualified by the SoC address decode.
- `ack` out 1: one-cycle completion pulse.
- `retry` out 1: tied 0.
- `irq` out 1: registered timer interrupt, level.

## Operation
- Register map, word index `addr[4:2]`:
  - 0 TIME_LO
  - 1 TIME_HI
  - 2 CMP_LO
  - 3 CMP_HI
  - 4 CTRL: bit0 `run`, bit1 `irq_en`, other bits read 0.
  - 5 PRESCALE: bits[15:0], upper bits read 0.
  - 6, 7 read 0; writes to them are ignored.
- Writes merge per byte lane through `select`. `select` = 0 makes a write a no-op that is still acked.
- Prescaler:
  - 16-bit down-counter `pre`, active only while `run` = 1.
  - When `pre` = 0 and `run` = 1, `time` increments by 1 (64-bit, wraps from all-ones to 0) and `pre` reloads from PRESCALE.
  - Otherwise `pre` decrements.
  - Tick period is PRESCALE+1 clocks. PRESCALE = 0 gives one tick per clock.
- A write to PRESCALE also loads `pre` with the new merged value. Clearing `run` freezes both `time` and `pre`.
- Atomic 64-bit read:
  - Reading TIME_LO latches the current `time[63:32]` into `hi_shadow`.
  - Reading TIME_HI returns `hi_shadow`, not the live value.
  - Software reads LO then HI.
- Writing TIME_LO or TIME_HI updates only that half. In a cycle where a TIME write and a tick coincide, the write wins and there is no increment that cycle.
- `irq` is registered as `irq_en && (time >= cmp)`, an unsigned 64-bit compare. It stays high until CMP is raised, TIME is lowered, or `irq_en` is cleared.
- Reset values:
  - `time` 0, `pre` 0, `hi_shadow` 0.
  - `cmp` all ones.
  - CTRL 0, PRESCALE 0.
  - `ack` 0, `out` 0, `irq` 0.

## Timing
- A request is accepted in every cycle where `strobe` = 1. `ack` = 1 follows exactly one cycle later, for one cycle, together with `out`.
- Back-to-back strobes give back-to-back acks, one per request. No wait states and no retry.
- Read data is the register value at the accept edge. A TIME_LO read taken in a tick cycle returns the pre-increment value, and `hi_shadow` latches the matching pre-increment high word.
- Register writes take effect at the accept edge. A read in the next cycle sees the new value.
- `irq` latency: `irq` changes on the edge after the one where the compare inputs change. Example: a CMP write accepted at edge N gives `irq` updated at edge N+1.
- Reset asserted mid-request forces `ack` = 0, `out` = 0 and `irq` = 0 on the following edge. The pending request is dropped, not acked.

## Structure
- Shared package `timer_pkg` holds:
  - the register index constants (TIME_LO, TIME_HI, CMP_LO, CMP_HI, CTRL, PRESCALE);
  - the CTRL bit positions;
  - the reset value of `cmp`.
- One sub-module `prescaler` (16-bit reloadable down-counter with `run`, `load`, `value` inputs and a `tick` output). The rest stays in `timer`.
- SoC integration:
  - `to_timer = 'b01 == addr[27:26]` plus a `from_timer` select flop.
  - `timer_out`, `timer_ack` and `timer_retry` are ORed into the existing bus muxes.

## Test plan
- Reset, then read all 8 indices: all read 0 except CMP_LO/CMP_HI = 0xFFFFFFFF. Each ack arrives 1 cycle after its strobe; `irq` = 0.
- Prescale:
  - Write PRESCALE = 3, CTRL = 1, run 40 clocks, read TIME_LO: value is 10 (±1 for the read edge).
  - With PRESCALE = 0, 40 clocks give time 40.
- High-word shadow: write TIME_LO = 0xFFFFFFFE, TIME_HI = 0, run with PRESCALE = 0, then read LO and HI. The pair is consistent across the carry: either (0xFFFFFFFF, 0) or (0x00000000, 1), never (0x00000000, 0).
- Compare:
  - Set CMP = 100 and CTRL = 3. `irq` rises on the cycle after `time` reaches 100.
  - Writing CMP_LO = 200 drops `irq` one cycle after the write's accept edge.
  - Clearing `irq_en` also drops `irq`.
- Byte select: write TIME_LO = 0x11223344 with `select` = 'b0101 over an old value of 0, `run` = 0. TIME_LO reads 0x00220044. A write with `select` = 0 still acks and changes nothing.
- Coincidence and reset:
  - A TIME_LO write landing on a tick edge stores the written value with no increment.
  - `reset` asserted the cycle after a strobe gives no ack, and all outputs are 0 on the next edge.
